signal_checker: RTL and testbench

Receive-side monitor for the 11-phase (x, y) pattern produced by the board's signal generator. It samples the two pattern lines every clock, hunts for frame alignment and verifies it over a full period. Once locked it tracks the pattern phase, flags mismatches and counts errors. It sits on the Basys board downstream of the generator, in the same clock domain, and drives the LEDs with the recovered phase.

---
 rtl/signal_checker_pkg.sv | 52 +++++
 rtl/signal_checker_pattern_rom.sv | 11 +
 rtl/signal_checker.sv | 130 +++++++++++++
 tb/tb_signal_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_checker_pkg.sv
// Shared pattern definitions for the 11-phase (x, y) generator/checker pair:
// phase constants, period length, per-phase symbols and checker state encoding.
package signal_checker_pkg;

    localparam int PERIOD = 11;

    localparam logic [3:0] S0  = 4'd0;
    localparam logic [3:0] S1  = 4'd1;
    localparam logic [3:0] S2  = 4'd2;
    localparam logic [3:0] S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4;
    localparam logic [3:0] S5  = 4'd5;
    localparam logic [3:0] S6  = 4'd6;
    localparam logic [3:0] S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8;
    localparam logic [3:0] S9  = 4'd9;
    localparam logic [3:0] S10 = 4'd10;

    localparam logic [3:0] PHASE_NONE = 4'hF;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_00 = 2'b00;
    localparam sym_t SYM_01 = 2'b01;
    localparam sym_t SYM_10 = 2'b10;
    localparam sym_t SYM_11 = 2'b11;

    typedef enum logic [1:0] {HUNT, CAND, VERIFY, LOCKED} state_t;

    // Expected {x,y} for a phase; anything outside 0..10 reads as 00.
    function automatic sym_t pattern_at(input logic [3:0] ph);
        case (ph)
            S0:      return SYM_00;
            S1:      return SYM_01;
            S2:      return SYM_10;
            S3:      return SYM_01;
            S4:      return SYM_00;
            S5:      return SYM_01;
            S6:      return SYM_00;
            S7:      return SYM_10;
            S8:      return SYM_00;
            S9:      return SYM_01;
            S10:     return SYM_00;
            default: return SYM_00;
        endcase
    endfunction

    function automatic logic [3:0] next_phase(input logic [3:0] ph);
        return (ph == 4'(PERIOD - 1)) ? S0 : ph + 4'd1;
    endfunction

endpackage

// File: rtl/signal_checker_pattern_rom.sv
// Combinational phase -> expected {x,y} lookup used by the checker.
module pattern_rom
    import signal_checker_pkg::*;
(
    input  logic [3:0] phase,
    output sym_t       pat
);

    assign pat = pattern_at(phase);

endmodule

// File: rtl/signal_checker.sv
// Receive-side monitor for the 11-phase (x, y) pattern: hunts alignment, verifies it,
// then tracks phase and flags errors. Define SIGNAL_CHECKER_ERRCNT_EN to build the error counter.
module signal_checker
    import signal_checker_pkg::*;
#(
    parameter int VERIFY_LEN = 11,
    parameter int MISS_MAX   = 3,
    parameter int ERRW       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            x,
    input  logic            y,
    output logic            locked,
    output logic [3:0]      phase,
    output logic            frame,
    output logic            err,
    output logic [ERRW-1:0] err_count,
    output logic [0:3]      led
);

    localparam int GW = $clog2(VERIFY_LEN + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    state_t        state;
    logic [3:0]    exp;
    logic [GW-1:0] good;
    logic [MW-1:0] miss;
    sym_t          sym;
    sym_t          exp_sym;
    logic          match;
    logic          err_hit;

    assign sym     = {x, y};
    assign match   = (sym == exp_sym);
    assign err_hit = (state == LOCKED) && !match;
    assign led     = phase;

    pattern_rom u_rom (
        .phase (exp),
        .pat   (exp_sym)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= HUNT;
            exp    <= S0;
            good   <= '0;
            miss   <= '0;
            locked <= 1'b0;
            phase  <= PHASE_NONE;
            frame  <= 1'b0;
            err    <= 1'b0;
        end else begin
            frame <= 1'b0;
            err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (sym == SYM_10) state <= CAND;
                end
                // A 10 only occurs at phase 2 or 7; the following symbol tells which.
                CAND: begin
                    case (sym)
                        SYM_01: begin
                            state <= VERIFY;
                            phase <= S3;
                            exp   <= S4;
                            good  <= GW'(1);
                        end
                        SYM_00: begin
                            state <= VERIFY;
                            phase <= S8;
                            exp   <= S9;
                            good  <= GW'(1);
                        end
                        SYM_10:  state <= CAND;
                        SYM_11:  state <= HUNT;
                    endcase
                end
                VERIFY: begin
                    exp <= next_phase(exp);
                    if (match) begin
                        phase <= exp;
                        good  <= good + GW'(1);
                        if (good + GW'(1) == GW'(VERIFY_LEN)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        state <= HUNT;
                        phase <= PHASE_NONE;
                        good  <= '0;
                    end
                end
                LOCKED: begin
                    exp   <= next_phase(exp);
                    phase <= exp;
                    frame <= (exp == S0);
                    err   <= !match;
                    if (match) begin
                        miss <= '0;
                    end else if (miss + MW'(1) == MW'(MISS_MAX)) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        phase  <= PHASE_NONE;
                        miss   <= '0;
                    end else begin
                        miss <= miss + MW'(1);
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef SIGNAL_CHECKER_ERRCNT_EN
    // Saturates at all-ones and survives loss of lock; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (err_hit && (err_count != {ERRW{1'b1}}))
            err_count <= err_count + ERRW'(1);
    end
`else
    assign err_count = '0;
    logic unused_err_hit;
    assign unused_err_hit = err_hit;
`endif

endmodule

// File: tb/tb_signal_checker.sv
// Randomized self-checking bench for signal_checker against a spec-level reference model.
module tb_signal_checker;

    localparam int VL = 11;
    localparam int MM = 3;
    localparam int EW = 8;

`ifdef SIGNAL_CHECKER_ERRCNT_EN
    localparam int SAT_EXP = 255;
    localparam int CNT5    = 5;
`else
    localparam int SAT_EXP = 0;
    localparam int CNT5    = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          x = 1'b0;
    logic          y = 1'b0;
    logic          locked;
    logic [3:0]    phase;
    logic          frame;
    logic          err;
    logic [EW-1:0] err_count;
    logic [0:3]    led;

    signal_checker #(.VERIFY_LEN(VL), .MISS_MAX(MM), .ERRW(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .locked    (locked),
        .phase     (phase),
        .frame     (frame),
        .err       (err),
        .err_count (err_count),
        .led       (led)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    int pat [11] = '{0, 1, 2, 1, 0, 1, 0, 2, 0, 1, 0};
    int gen_ph   = 0;

    // Reference model: mode 0 hunting, 1 saw a 10, 2 confirming, 3 aligned.
    int m_mode, m_exp, m_good, m_miss, m_cnt, m_phase;
    bit m_locked, m_frame, m_err;

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_good = 0; m_miss = 0; m_cnt = 0;
        m_phase = 15; m_locked = 0; m_frame = 0; m_err = 0;
    endtask

    task automatic model(input int s);
        m_frame = 0;
        m_err   = 0;
        if (m_mode == 0) begin
            if (s == 2) m_mode = 1;
        end else if (m_mode == 1) begin
            if (s == 1 || s == 0) begin
                m_mode = 2; m_good = 1;
                m_phase = (s == 1) ? 3 : 8;
                m_exp   = m_phase + 1;
            end else if (s == 3) m_mode = 0;
        end else if (m_mode == 2) begin
            if (s == pat[m_exp]) begin
                m_phase = m_exp;
                m_good++;
                if (m_good == VL) begin m_mode = 3; m_locked = 1; end
            end else begin
                m_mode = 0; m_phase = 15;
            end
            m_exp = (m_exp + 1) % 11;
        end else begin
            m_phase = m_exp;
            m_frame = (m_exp == 0);
            if (s == pat[m_exp]) m_miss = 0;
            else begin
                m_err = 1;
                if (m_cnt < (1 << EW) - 1) m_cnt++;
                m_miss++;
            end
            if (m_miss == MM) begin
                m_mode = 0; m_locked = 0; m_phase = 15; m_miss = 0;
            end
            m_exp = (m_exp + 1) % 11;
        end
    endtask

    function automatic int exp_cnt();
`ifdef SIGNAL_CHECKER_ERRCNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic logic [18:0] obs();
        return {locked, phase, frame, err, err_count, led};
    endfunction

    function automatic logic [18:0] mdl();
        return {m_locked, 4'(m_phase), m_frame, m_err, EW'(exp_cnt()), 4'(m_phase)};
    endfunction

    task automatic step(input int s);
        x = s[1];
        y = s[0];
        @(posedge clk);
        #1;
        model(s);
    endtask

    task automatic clean();
        step(pat[gen_ph]);
        gen_ph = (gen_ph + 1) % 11;
    endtask

    task automatic bad(input int s);
        step(s);
        gen_ph = (gen_ph + 1) % 11;
    endtask

    function automatic int wrong_sym();
        return int'((pat[gen_ph] + $urandom_range(1, 3)) % 4);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        x = 1'b0;
        y = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        gen_ph = 0;
    endtask

    task automatic acquire_check(input string tag);
        int first_frame;
        first_frame = 0;
        for (int i = 1; i <= 30; i++) begin
            clean();
            compared++;
            if (obs() !== mdl()) begin
                failed++;
                $display("FAIL %s edge %0d: got %h want %h", tag, i, obs(), mdl());
            end
            if (frame === 1'b1 && first_frame == 0) first_frame = i;
            if (i == 4) begin
                compared++;
                if (phase !== 4'd3) begin
                    failed++;
                    $display("FAIL %s verify phase: got %0d want 3", tag, phase);
                end
            end
            if (i == 13 || i == 14) begin
                compared++;
                if (locked !== (i == 14)) begin
                    failed++;
                    $display("FAIL %s lock edge %0d: got %b want %b", tag, i, locked, i == 14);
                end
            end
        end
        compared++;
        if (first_frame != 23) begin
            failed++;
            $display("FAIL %s first frame: got edge %0d want edge 23", tag, first_frame);
        end
        compared++;
        if (err_count !== '0) begin
            failed++;
            $display("FAIL %s err_count: got %0d want 0", tag, err_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (obs() !== {1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 4'hF}) begin
            failed++;
            $display("FAIL reset values: got %h want %h", obs(), {1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 4'hF});
        end
    endtask

    task automatic test_acquisition();
        do_reset();
        acquire_check("acq");
    endtask

    task automatic test_single_corruption();
        while (gen_ph != 5) clean();
        bad(3);
        compared++;
        if ({err, locked, phase} !== {1'b1, 1'b1, 4'd5} || err_count !== EW'(exp_cnt())) begin
            failed++;
            $display("FAIL single hit: got err=%b locked=%b phase=%0d cnt=%0d want 1 1 5 %0d",
                     err, locked, phase, err_count, exp_cnt());
        end
        for (int i = 0; i < 3; i++) begin
            clean();
            compared++;
            if ({err, locked, phase} !== {1'b0, 1'b1, 4'(6 + i)} || obs() !== mdl()) begin
                failed++;
                $display("FAIL single after %0d: got %h want %h", i, obs(), mdl());
            end
        end
    endtask

    task automatic test_loss_of_lock();
        for (int k = 0; k < 3; k++) begin
            bad(wrong_sym());
            compared++;
            if (err !== 1'b1 || obs() !== mdl()) begin
                failed++;
                $display("FAIL loss miss %0d: got %h want %h", k, obs(), mdl());
            end
        end
        compared++;
        if (locked !== 1'b0 || phase !== 4'hF) begin
            failed++;
            $display("FAIL loss state: got locked=%b phase=%h want 0 f", locked, phase);
        end
        for (int i = 0; i < 30; i++) begin
            clean();
            compared++;
            if (obs() !== mdl()) begin
                failed++;
                $display("FAIL relock cyc %0d: got %h want %h", i, obs(), mdl());
            end
        end
        compared++;
        if (locked !== 1'b1 || err_count !== EW'(exp_cnt())) begin
            failed++;
            $display("FAIL relock end: got locked=%b cnt=%0d want 1 %0d", locked, err_count, exp_cnt());
        end
    endtask

    task automatic test_false_candidate();
        int syms [6] = '{2, 3, 2, 0, 2, 0};
        bit err_seen;
        for (int k = 0; k < 3; k++) bad(wrong_sym());
        err_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(syms[i]);
            err_seen |= err;
            compared++;
            if (obs() !== mdl()) begin
                failed++;
                $display("FAIL falsecand step %0d: got %h want %h", i, obs(), mdl());
            end
            if (i == 3) begin
                compared++;
                if (phase !== 4'd8) begin
                    failed++;
                    $display("FAIL falsecand verify phase: got %0d want 8", phase);
                end
            end
        end
        compared++;
        if (phase !== 4'hF || locked !== 1'b0 || err_seen !== 1'b0) begin
            failed++;
            $display("FAIL falsecand end: got phase=%h locked=%b errseen=%b want f 0 0", phase, locked, err_seen);
        end
    endtask

    task automatic test_saturation();
        int nmis;
        do_reset();
        for (int i = 0; i < 30; i++) clean();
        nmis = 0;
        while (nmis < 300) begin
            repeat ($urandom_range(1, MM - 1)) begin
                bad(wrong_sym());
                nmis++;
                compared++;
                if (obs() !== mdl()) begin
                    failed++;
                    $display("FAIL sat miss %0d: got %h want %h", nmis, obs(), mdl());
                end
            end
            repeat ($urandom_range(1, 3)) begin
                clean();
                compared++;
                if (obs() !== mdl()) begin
                    failed++;
                    $display("FAIL sat clean after %0d: got %h want %h", nmis, obs(), mdl());
                end
            end
        end
        compared++;
        if (err_count !== EW'(SAT_EXP) || locked !== 1'b1) begin
            failed++;
            $display("FAIL saturation: got cnt=%0d locked=%b want %0d 1", err_count, locked, SAT_EXP);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        for (int i = 0; i < 30; i++) clean();
        for (int k = 0; k < 5; k++) begin
            bad(wrong_sym());
            clean();
            clean();
        end
        compared++;
        if (err_count !== EW'(CNT5) || locked !== 1'b1) begin
            failed++;
            $display("FAIL midlock setup: got cnt=%0d locked=%b want %0d 1", err_count, locked, CNT5);
        end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compared++;
        if (obs() !== {1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 4'hF}) begin
            failed++;
            $display("FAIL async reset: got %h want %h", obs(), {1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 4'hF});
        end
        @(negedge clk);
        reset = 1'b0;
        gen_ph = 0;
        acquire_check("reacq");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 8) bad(int'($urandom_range(0, 3)));
            else if ($urandom_range(0, 199) == 0) begin
                gen_ph = int'($urandom_range(0, 10));
                clean();
            end else clean();
            compared++;
            if (obs() !== mdl()) begin
                failed++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs(), mdl());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acquisition();
        test_single_corruption();
        test_loss_of_lock();
        test_false_candidate();
        test_saturation();
        test_reset_mid_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
